// File: rtl/apb_pwm_ramp_master.sv
// ---------------------------------------------------------------------------
// apb_pwm_ramp_master
//
// APB master that programs a downstream APB PWM slave without CPU help.
// On an accepted start it writes period, size, the initial pulse and enable=1.
// It then walks the pulse register from cfg_pstart to cfg_pend in cfg_step
// increments, waiting cfg_hold cycles between pulse writes.
// A stop request makes it write enable=0 and return to idle.
//
// Ports
//   PCLK, PRESET          clock; synchronous active-high reset
//   start, stop           one-cycle control requests
//   cfg_period/size/pstart/pend/step/hold   ramp configuration, latched on start
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA        APB request outputs (registered)
//   PREADY/PSLAVEERR                        APB completion inputs
//   busy, done, err                         status (registered; err is sticky)
// ---------------------------------------------------------------------------
module apb_pwm_ramp_master #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          TIMEOUT   = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] cfg_period,
    input  logic [7:0]  cfg_size,
    input  logic [31:0] cfg_pstart,
    input  logic [31:0] cfg_pend,
    input  logic [15:0] cfg_step,
    input  logic [31:0] cfg_hold,
    output logic [31:0] PADDR,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    input  logic        PREADY,
    input  logic        PSLAVEERR,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SETUP      = 3'd1,
        S_ACCESS     = 3'd2,
        S_HOLD       = 3'd3,
        S_OFF_SETUP  = 3'd4,
        S_OFF_ACCESS = 3'd5
    } state_t;

    // Which register the current/next ramp-sequence transfer targets.
    localparam logic [2:0] PH_PERIOD = 3'd0;
    localparam logic [2:0] PH_SIZE   = 3'd1;
    localparam logic [2:0] PH_PULSE0 = 3'd2;
    localparam logic [2:0] PH_ENABLE = 3'd3;
    localparam logic [2:0] PH_RAMP   = 3'd4;

    localparam logic [31:0] OFS_PERIOD = 32'h0000_0000;
    localparam logic [31:0] OFS_PULSE  = 32'h0000_0004;
    localparam logic [31:0] OFS_SIZE   = 32'h0000_0008;
    localparam logic [31:0] OFS_ENABLE = 32'h0000_000C;
    localparam logic [31:0] TMO_LAST   = 32'(TIMEOUT - 1);

    state_t      r_state;
    logic [2:0]  r_phase;
    logic [7:0]  r_size;
    logic [31:0] r_cur;
    logic [31:0] r_pend;
    logic [15:0] r_step;
    logic [31:0] r_hold;
    logic        r_dir_up;
    logic [31:0] r_hold_cnt;
    logic [31:0] r_tcnt;
    logic        r_stop_pend;

    logic [31:0] r_paddr;
    logic [31:0] r_pwdata;
    logic        r_psel;
    logic        r_penable;
    logic        r_pwrite;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    state_t      w_state_nxt;
    logic [2:0]  w_phase_nxt;
    logic        w_accept;
    logic        w_cur_load;
    logic        w_set_err;
    logic        w_set_done;
    logic        w_xfer_ok;
    logic        w_xfer_err;
    logic        w_stop_req;
    logic [32:0] w_sum;
    logic [32:0] w_diff;
    logic [31:0] w_next_pulse;

    logic [31:0] w_paddr_nxt;
    logic [31:0] w_pwdata_nxt;
    logic        w_psel_nxt;
    logic        w_penable_nxt;
    logic        w_busy_nxt;
    logic        w_err_nxt;

    // Transfer outcome in ACCESS: an error reply or running out of the wait budget both abort.
    always_comb begin
        w_xfer_ok  = PREADY & ~PSLAVEERR;
        w_xfer_err = (PREADY & PSLAVEERR) | (~PREADY & (r_tcnt == TMO_LAST));
        w_stop_req = stop | r_stop_pend;
    end

    // Next pulse value; 33-bit math so a carry/borrow clamps to the end value instead of wrapping.
    always_comb begin
        w_sum  = {1'b0, r_cur} + {17'b0, r_step};
        w_diff = {1'b0, r_cur} - {17'b0, r_step};
        if (r_step == 16'd0) begin
            w_next_pulse = r_pend;
        end else if (r_dir_up) begin
            if (w_sum[32] || (w_sum[31:0] > r_pend)) begin
                w_next_pulse = r_pend;
            end else begin
                w_next_pulse = w_sum[31:0];
            end
        end else begin
            if (w_diff[32] || (w_diff[31:0] < r_pend)) begin
                w_next_pulse = r_pend;
            end else begin
                w_next_pulse = w_diff[31:0];
            end
        end
    end

    // Next-state logic for the transfer sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_accept    = 1'b0;
        w_cur_load  = 1'b0;
        w_set_err   = 1'b0;
        w_set_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // start wins over a simultaneous stop; stop is meaningless when idle
                if (start) begin
                    w_state_nxt = S_SETUP;
                    w_phase_nxt = PH_PERIOD;
                    w_accept    = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SETUP: begin
                w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                if (w_xfer_err) begin
                    w_state_nxt = S_IDLE;
                    w_set_err   = 1'b1;
                end else if (w_xfer_ok) begin
                    if (w_stop_req) begin
                        w_state_nxt = S_OFF_SETUP;
                    end else if (r_phase < PH_ENABLE) begin
                        w_state_nxt = S_SETUP;
                        w_phase_nxt = r_phase + 3'd1;
                    end else if (r_cur == r_pend) begin
                        w_state_nxt = S_IDLE;
                        w_set_done  = 1'b1;
                    end else if (r_hold == 32'd0) begin
                        w_state_nxt = S_SETUP;
                        w_phase_nxt = PH_RAMP;
                        w_cur_load  = 1'b1;
                    end else begin
                        w_state_nxt = S_HOLD;
                    end
                end else begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_HOLD: begin
                if (w_stop_req) begin
                    w_state_nxt = S_OFF_SETUP;
                end else if (r_hold_cnt == (r_hold - 32'd1)) begin
                    w_state_nxt = S_SETUP;
                    w_phase_nxt = PH_RAMP;
                    w_cur_load  = 1'b1;
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_OFF_SETUP: begin
                w_state_nxt = S_OFF_ACCESS;
            end
            S_OFF_ACCESS: begin
                if (w_xfer_err) begin
                    w_state_nxt = S_IDLE;
                    w_set_err   = 1'b1;
                end else if (w_xfer_ok) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_OFF_ACCESS;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode: values the registered outputs take on the next edge.
    always_comb begin
        w_paddr_nxt   = r_paddr;
        w_pwdata_nxt  = r_pwdata;
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
        w_busy_nxt    = (w_state_nxt != S_IDLE);
        case (w_state_nxt)
            S_SETUP: begin
                w_psel_nxt = 1'b1;
                // address/data are loaded once on SETUP entry and held through ACCESS
                case (w_phase_nxt)
                    PH_PERIOD: begin
                        w_paddr_nxt  = BASE_ADDR + OFS_PERIOD;
                        w_pwdata_nxt = cfg_period;
                    end
                    PH_SIZE: begin
                        w_paddr_nxt  = BASE_ADDR + OFS_SIZE;
                        w_pwdata_nxt = {24'd0, r_size};
                    end
                    PH_PULSE0: begin
                        w_paddr_nxt  = BASE_ADDR + OFS_PULSE;
                        w_pwdata_nxt = r_cur;
                    end
                    PH_ENABLE: begin
                        w_paddr_nxt  = BASE_ADDR + OFS_ENABLE;
                        w_pwdata_nxt = 32'h0000_0001;
                    end
                    PH_RAMP: begin
                        w_paddr_nxt  = BASE_ADDR + OFS_PULSE;
                        w_pwdata_nxt = w_next_pulse;
                    end
                    default: begin
                        w_paddr_nxt  = BASE_ADDR;
                        w_pwdata_nxt = 32'd0;
                    end
                endcase
            end
            S_ACCESS: begin
                w_psel_nxt    = 1'b1;
                w_penable_nxt = 1'b1;
            end
            S_OFF_SETUP: begin
                w_psel_nxt   = 1'b1;
                w_paddr_nxt  = BASE_ADDR + OFS_ENABLE;
                w_pwdata_nxt = 32'd0;
            end
            S_OFF_ACCESS: begin
                w_psel_nxt    = 1'b1;
                w_penable_nxt = 1'b1;
            end
            default: begin
                w_psel_nxt    = 1'b0;
                w_penable_nxt = 1'b0;
            end
        endcase
        if (w_accept) begin
            w_err_nxt = 1'b0;
        end else if (w_set_err) begin
            w_err_nxt = 1'b1;
        end else begin
            w_err_nxt = r_err;
        end
    end

    // State register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= S_IDLE;
            r_phase <= PH_PERIOD;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    // Latched configuration, current pulse value and cycle counters.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_size      <= 8'd0;
            r_cur       <= 32'd0;
            r_pend      <= 32'd0;
            r_step      <= 16'd0;
            r_hold      <= 32'd0;
            r_dir_up    <= 1'b0;
            r_hold_cnt  <= 32'd0;
            r_tcnt      <= 32'd0;
            r_stop_pend <= 1'b0;
        end else begin
            if (w_accept) begin
                r_size   <= cfg_size;
                r_cur    <= cfg_pstart;
                r_pend   <= cfg_pend;
                r_step   <= cfg_step;
                r_hold   <= cfg_hold;
                r_dir_up <= (cfg_pend >= cfg_pstart);
            end else if (w_cur_load) begin
                r_cur <= w_next_pulse;
            end else begin
                r_cur <= r_cur;
            end
            r_hold_cnt <= (r_state == S_HOLD) ? (r_hold_cnt + 32'd1) : 32'd0;
            r_tcnt     <= ((r_state == S_ACCESS) || (r_state == S_OFF_ACCESS)) ?
                          (r_tcnt + 32'd1) : 32'd0;
            // a stop seen mid-transfer is remembered until that transfer completes
            if (w_accept || (r_state == S_IDLE)) begin
                r_stop_pend <= 1'b0;
            end else if (stop) begin
                r_stop_pend <= 1'b1;
            end else begin
                r_stop_pend <= r_stop_pend;
            end
        end
    end

    // Registered APB and status outputs.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_paddr   <= 32'd0;
            r_pwdata  <= 32'd0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_paddr   <= w_paddr_nxt;
            r_pwdata  <= w_pwdata_nxt;
            r_psel    <= w_psel_nxt;
            r_penable <= w_penable_nxt;
            r_pwrite  <= w_psel_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_set_done;
            r_err     <= w_err_nxt;
        end
    end

    assign PADDR   = r_paddr;
    assign PWDATA  = r_pwdata;
    assign PSEL    = r_psel;
    assign PENABLE = r_penable;
    assign PWRITE  = r_pwrite;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;

endmodule
